// File: rtl/fire_pkg.sv
// Shared definitions for the fire-layer squeeze/expand datapath.
package fire_pkg;

    // Fixed-point word width used across all fire layers.
    localparam int WIDTH = 16;

    // Squeeze output channels and output feature-map side, per fire.
    localparam int FIRE8_DSP_NO = 112;
    localparam int FIRE8_WOUT   = 8;
    localparam int FIRE9_DSP_NO = 112;
    localparam int FIRE9_WOUT   = 8;

    typedef logic signed [WIDTH-1:0] word_t;

    // Writer sequencing: wait for a pixel, stream its channels, acknowledge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } wr_state_t;

endpackage

// File: rtl/squeeze_ofm_writer_relu.sv
// Combinational ReLU on one signed fixed-point word.
module relu_word #(
    parameter int W = 16
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    // Negative values clamp to zero; everything else passes untouched.
    assign y_o = x_i[W-1] ? '0 : x_i;

endmodule

// File: rtl/squeeze_ofm_writer.sv
// Captures one pixel of squeeze results, applies ReLU and writes the
// channels one per cycle into the expand-layer feature-map RAM
// (channel-major layout), then acknowledges the squeeze engine.
module squeeze_ofm_writer #(
    parameter int WIDTH  = fire_pkg::WIDTH,
    parameter int DSP_NO = fire_pkg::FIRE8_DSP_NO,
    parameter int WOUT   = fire_pkg::FIRE8_WOUT,
    parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_i,
    input  logic                    finish_i,
    input  logic [DSP_NO*WIDTH-1:0] ofm_i,
    output logic                    ram_we_o,
    output logic [ADDR_W-1:0]       ram_addr_o,
    output logic [WIDTH-1:0]        ram_data_o,
    output logic                    ram_feedback_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overrun_o
);

    import fire_pkg::*;

    localparam int PIX_N = WOUT * WOUT;
    localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
    localparam int PIX_W = (PIX_N > 1) ? $clog2(PIX_N) : 1;
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_N - 1);

    wr_state_t        state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             fin_pend_q, fin_pend_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] buf_q [DSP_NO];
    logic [WIDTH-1:0] cur_word;
    logic [WIDTH-1:0] relu_out;

    // Capture buffer: only a sample accepted in IDLE loads it, so a dropped
    // sample can never corrupt a pixel that is still draining.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && sample_i) begin
            for (int i = 0; i < DSP_NO; i++) begin
                buf_q[i] <= ofm_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign cur_word = buf_q[ch_q];

    relu_word #(.W(WIDTH)) u_relu (
        .x_i (cur_word),
        .y_o (relu_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sample_i) state_d = DRAIN;
            DRAIN:   if (ch_q == CH_LAST) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and flags: channel/pixel position, pending finish, done pulse.
    always_comb begin
        ch_d       = ch_q;
        pix_d      = pix_q;
        fin_pend_d = fin_pend_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q | (sample_i && state_q != IDLE);
        case (state_q)
            IDLE: begin
                ch_d = '0;
                if (finish_i) begin
                    if (sample_i) begin
                        // A pixel is starting; finish after it is stored.
                        fin_pend_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        pix_d  = '0;
                    end
                end
            end
            DRAIN: begin
                ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
                if (finish_i) fin_pend_d = 1'b1;
            end
            ACK: begin
                ch_d = '0;
                if (fin_pend_q || finish_i) begin
                    // done lands the cycle after feedback, never with it.
                    done_d     = 1'b1;
                    pix_d      = '0;
                    fin_pend_d = 1'b0;
                end else begin
                    pix_d = (pix_q == PIX_LAST) ? '0 : pix_q + PIX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Counter and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q       <= '0;
            pix_q      <= '0;
            fin_pend_q <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            fin_pend_q <= fin_pend_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    // Outputs decode straight from state so a reset silences the RAM port
    // in the same instant; address/data are zeroed outside DRAIN.
    always_comb begin
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        ram_data_o     = '0;
        ram_feedback_o = 1'b0;
        busy_o         = (state_q != IDLE);
        done_o         = done_q;
        overrun_o      = overrun_q;
        case (state_q)
            DRAIN: begin
                ram_we_o   = 1'b1;
                ram_addr_o = ADDR_W'(int'(ch_q) * PIX_N + int'(pix_q));
                ram_data_o = relu_out;
            end
            ACK:     ram_feedback_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_squeeze_ofm_writer.sv
// Scoreboard bench for squeeze_ofm_writer: stimulus pushes expected RAM
// writes, feedback cycles and done cycles; a negedge monitor pops and checks.
module tb_squeeze_ofm_writer;

    localparam int W  = 16;
    localparam int N  = 112;
    localparam int WO = 8;
    localparam int PN = WO * WO;
    localparam int AW = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic            sample_i;
    logic            finish_i;
    logic [N*W-1:0]  ofm;
    logic            ram_we_o;
    logic [AW-1:0]   ram_addr_o;
    logic [W-1:0]    ram_data_o;
    logic            ram_feedback_o;
    logic            busy_o;
    logic            done_o;
    logic            overrun_o;

    squeeze_ofm_writer #(.WIDTH(W), .DSP_NO(N), .WOUT(WO), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (sample_i),
        .finish_i       (finish_i),
        .ofm_i          (ofm),
        .ram_we_o       (ram_we_o),
        .ram_addr_o     (ram_addr_o),
        .ram_data_o     (ram_data_o),
        .ram_feedback_o (ram_feedback_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .overrun_o      (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_fb[$];
    int  exp_done[$];
    int  cur[N];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        int  c;
        if (!rst) begin
            if (ram_we_o) begin
                if (exp_wr.size() == 0) begin
                    chk("write_expected", 0, 1);
                end else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(ram_addr_o), e.addr);
                    chk("wr_data", int'(ram_data_o), e.data);
                end
            end
            if (ram_feedback_o) begin
                if (exp_fb.size() == 0) begin
                    chk("feedback_expected", 0, 1);
                end else begin
                    c = exp_fb.pop_front();
                    chk("feedback_cycle", cyc, c);
                end
            end
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    chk("done_expected", 0, 1);
                end else begin
                    c = exp_done.pop_front();
                    chk("done_cycle", cyc, c);
                end
            end
        end
    end

    // Issue one sample of cur[]; expect the first nwr channel writes at pix.
    task automatic send(input int pix, input int nwr, output int s);
        @(negedge clk);
        for (int c = 0; c < N; c++) ofm[c*W +: W] = cur[c][W-1:0];
        sample_i = 1'b1;
        s = cyc;
        for (int c = 0; c < nwr; c++) begin
            wr_t e;
            e.addr = c * PN + pix;
            e.data = (cur[c] < 0) ? 0 : cur[c];
            exp_wr.push_back(e);
        end
        if (nwr == N) exp_fb.push_back(s + N + 1);
        @(negedge clk);
        sample_i = 1'b0;
    endtask

    task automatic pulse_finish(output int s);
        @(negedge clk);
        finish_i = 1'b1;
        s = cyc;
        @(negedge clk);
        finish_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},       int'(ram_we_o), 0);
        chk({tag, "_addr"},     int'(ram_addr_o), 0);
        chk({tag, "_data"},     int'(ram_data_o), 0);
        chk({tag, "_feedback"}, int'(ram_feedback_o), 0);
        chk({tag, "_busy"},     int'(busy_o), 0);
        chk({tag, "_done"},     int'(done_o), 0);
        chk({tag, "_overrun"},  int'(overrun_o), 0);
    endtask

    initial begin
        int s;
        int f;
        rst      = 1'b1;
        sample_i = 1'b0;
        finish_i = 1'b0;
        ofm      = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // 1: ramp through zero, pix 0.
        for (int c = 0; c < N; c++) cur[c] = c - 56;
        send(0, N, s);
        $display("T1 sample at cycle %0d", s);
        repeat (N + 5) @(negedge clk);
        chk("t1_busy_idle", int'(busy_o), 0);

        // 5: finish in IDLE clears pix; done next cycle, no writes.
        pulse_finish(f);
        exp_done.push_back(f + 1);
        $display("T5 finish at cycle %0d", f);
        repeat (4) @(negedge clk);

        // 2: a whole frame of pixels, spaced 400 cycles.
        for (int k = 0; k < PN; k++) begin
            for (int c = 0; c < N; c++) cur[c] = ((c * 37 + k * 101) % 4096) - 2048;
            send(k, N, s);
            $display("T2 pixel %0d sample at cycle %0d", k, s);
            repeat (398) @(negedge clk);
        end
        chk("t2_overrun", int'(overrun_o), 0);

        // 3: second sample 10 cycles after the first is dropped.
        for (int c = 0; c < N; c++) cur[c] = c * 3;
        send(0, N, s);
        $display("T3 sample at cycle %0d", s);
        repeat (8) @(negedge clk);
        for (int c = 0; c < N; c++) cur[c] = 1000 + c;
        send(0, 0, f);
        $display("T3 dropped sample at cycle %0d", f);
        repeat (N + 5) @(negedge clk);
        chk("t3_overrun", int'(overrun_o), 1);

        // 4: finish mid-drain; feedback then done; next pixel at pix 0.
        for (int c = 0; c < N; c++) cur[c] = 200 - c * 4;
        send(1, N, s);
        exp_done.push_back(s + N + 2);
        repeat (30) @(negedge clk);
        pulse_finish(f);
        $display("T4 sample at cycle %0d finish at cycle %0d", s, f);
        repeat (N) @(negedge clk);
        for (int c = 0; c < N; c++) cur[c] = c + 1;
        send(0, N, s);
        $display("T4 follow-up sample at cycle %0d", s);
        repeat (N + 5) @(negedge clk);

        // 6: reset during write 50 silences the port immediately.
        for (int c = 0; c < N; c++) cur[c] = 500 - c;
        send(1, 51, s);
        for (int i = 0; i < 200 && cyc != s + 51; i++) @(negedge clk);
        chk("t6_reached_write50", cyc, s + 51);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t6_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < N; c++) cur[c] = c - 10;
        send(0, N, s);
        $display("T6 post-reset sample at cycle %0d", s);
        repeat (N + 5) @(negedge clk);

        chk("left_writes",   exp_wr.size(), 0);
        chk("left_feedback", exp_fb.size(), 0);
        chk("left_done",     exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
